// File: rtl/mem_stage.sv
// mem_stage: RV32 memory access stage with a req/ready data port,
// byte-lane alignment, load extension and the M/W pipeline register.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  RegWriteM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [1:0]            ResultSrcM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic          acc, bad_f3, mis, tmo, req, done, wload;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ldata, res;

  assign off    = ALUResultM[1:0];
  assign acc    = MemReadM | MemWriteM;
  assign bad_f3 = (Funct3M == 3'b011) | (Funct3M[2:1] == 2'b11)
                | (MemWriteM & Funct3M[2]);
  assign mis    = acc & (bad_f3
                | ((Funct3M[1:0] == 2'b01) & off[0])
                | ((Funct3M[1:0] == 2'b10) & (off != 2'b00)));
  assign tmo    = (state == S_WAIT) & (cnt == CW'(TIMEOUT_CYCLES));

  // Request is withdrawn in the timeout cycle; a late ready is then ignored.
  assign req       = ~rst & acc & ~mis & ~tmo;
  assign done      = req & mem_ready;
  assign wload     = ~acc | done;
  assign mem_req   = req;
  assign StallM    = req & ~mem_ready;
  assign MisalignM = ~rst & mis;
  assign BusErrM   = ~rst & tmo;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[31:2], 2'b00};

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (MemWriteM) begin
      unique case (1'b1)
        Funct3M[1:0] == 2'b00: begin
          mem_wdata = {4{WriteDataM[7:0]}};
          mem_be    = 4'b0001 << off;
        end
        Funct3M[1:0] == 2'b01: begin
          mem_wdata = {2{WriteDataM[15:0]}};
          mem_be    = off[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  assign lb = 8'(mem_rdata >> {off, 3'b000});
  assign lh = 16'(mem_rdata >> {off[1], 4'b0000});

  always_comb begin
    unique case (1'b1)
      Funct3M[1:0] == 2'b00:
        ldata = {{24{~Funct3M[2] & lb[7]}}, lb};
      Funct3M[1:0] == 2'b01:
        ldata = {{16{~Funct3M[2] & lh[15]}}, lh};
      default:
        ldata = mem_rdata;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      ResultSrcM == 2'b01: res = ldata;
      ResultSrcM == 2'b10: res = PCPlus4M;
      default:             res = ALUResultM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (StallM) begin
        state <= S_WAIT;
        cnt   <= CW'(1);
      end
    end else if (StallM) begin
      cnt <= cnt + 1'b1;
    end else begin
      state <= S_IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
    end else if (wload) begin
      ResultW   <= res;
      RdW       <= RdM;
      RegWriteW <= RegWriteM & ~MemWriteM;
    end else begin
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
    end
  end

endmodule
